clb_cfg_loader: RTL

// Configuration sequencer for a grid of CLB tiles. Accepts a stream of 23-bit

---
 rtl/clb_cfg_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/clb_cfg_loader.sv
// Configuration sequencer: streams N_CLB config words into CLB tiles in index
// order via a one-hot write strobe, then validates a trailing XOR checksum word.
module clb_cfg_loader #(
  parameter int N_CLB  = 16,
  parameter int WORD_W = 23,
  parameter int IDX_W  = $clog2(N_CLB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [N_CLB-1:0]  clb_wr_en,
  output logic [WORD_W-1:0] clb_bits,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLB - 1);
  localparam logic [N_CLB-1:0] WR_BASE  = N_CLB'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] chk;
  logic              accept;

  assign accept = cfg_valid && cfg_ready;

  // Next-state selection; abort outranks any accept while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
        else       state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (abort)                          state_nxt = S_IDLE;
        else if (accept && idx == LAST_IDX) state_nxt = S_CHECK;
        else                                state_nxt = S_LOAD;
      end
      S_CHECK: begin
        if (abort || accept) state_nxt = S_IDLE;
        else                 state_nxt = S_CHECK;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      chk       <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      clb_wr_en <= '0;
      clb_bits  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt != S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      clb_wr_en <= '0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= '0;
            chk <= '0;
            err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (accept) begin
            clb_bits  <= cfg_data;
            clb_wr_en <= WR_BASE << idx;
            chk       <= chk ^ cfg_data;
            // idx parks on the last tile so it never wraps inside a load.
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
          end
        end
        S_CHECK: begin
          if (abort) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (accept) begin
            done <= 1'b1;
            err  <= (cfg_data != chk);
          end
        end
        default: begin
          idx <= '0;
          chk <= '0;
        end
      endcase
    end
  end

endmodule
